uart_console_rx: RTL

- 8N1 UART receiver with a small FIFO, clocked on the 125 MHz system clock.
- Sits directly downstream of the PCIe system's UART conduit. Its serial input is wired to uart_conduit_txd.
- Deserialises console bytes emitted by the system and presents them on a valid/ready byte stream. Consumers are on-board logging/loopback logic.
- Detects framing errors and FIFO overflow.

---
 rtl/uart_console_rx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_console_rx.sv
// rtl/uart_console_rx.sv - 8N1 console UART receiver with first-word fall-through byte FIFO
module uart_console_rx #(
  parameter int CLK_HZ       = 125000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk_125_clk,
  input  logic                          rst_125_reset,
  input  logic                          uart_conduit_txd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_framing_err,
  output logic                          rx_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [CW-1:0] C_HALF_END = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] C_BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] C_DEPTH    = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  state_t        r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_framing_err;
  logic          r_overflow;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic w_stop_sample;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_push_ok;

  assign w_stop_sample = (r_state == S_STOP) && (r_clk_cnt == C_BIT_END);
  assign w_push        = w_stop_sample && r_sync2;
  assign w_pop         = (r_level != '0) && rx_ready;
  assign w_full        = (r_level == C_DEPTH);
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign w_push_ok     = w_push && (!w_full || w_pop);

  always_ff @(posedge clk_125_clk) begin
    if (rst_125_reset) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_state       <= S_IDLE;
      r_clk_cnt     <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_framing_err <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_sync1       <= uart_conduit_txd;
      r_sync2       <= r_sync1;
      r_framing_err <= 1'b0;
      if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (!r_sync2) begin
            r_clk_cnt <= '0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (r_clk_cnt == C_HALF_END) begin
            r_clk_cnt <= '0;
            if (!r_sync2) begin
              r_bit_idx <= '0;
              r_state   <= S_DATA;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_clk_cnt == C_BIT_END) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_sync2, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_clk_cnt == C_BIT_END) begin
            r_clk_cnt <= '0;
            if (r_sync2) begin
              r_state <= S_IDLE;
            end else begin
              r_framing_err <= 1'b1;
              r_state       <= S_BREAK;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (r_sync2) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_125_clk) begin
    if (rst_125_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign rx_data        = r_mem[r_rd_ptr];
  assign rx_valid       = (r_level != '0);
  assign fifo_level     = r_level;
  assign rx_framing_err = r_framing_err;
  assign rx_overflow    = r_overflow;

endmodule
